// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit word and
// streams the words through a small FIFO into instruction memory.
module inst_encoder #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               fmt,
    input  logic [6:0]               opCODE,
    input  logic [4:0]               wR,
    input  logic [4:0]               rR1,
    input  logic [4:0]               rR2,
    input  logic [2:0]               fun3,
    input  logic [6:0]               fun7,
    input  logic [31:0]              imm,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [31:0]              mem_wdata,
    input  logic                     mem_ready,
    output logic                     err,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    logic [31:0]   buf_q [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          alive;

    logic [31:0]   enc_c;
    logic          legal_c;
    logic          accept_c;
    logic          push_c;
    logic          pop_c;

    // Field packing per instruction format; fmt 6/7 flagged illegal.
    always_comb begin
        enc_c   = 32'd0;
        legal_c = 1'b1;
        case (fmt)
            FMT_R: enc_c = {fun7, rR2, rR1, fun3, wR, opCODE};
            FMT_I: enc_c = {imm[11:0], rR1, fun3, wR, opCODE};
            FMT_S: enc_c = {imm[11:5], rR2, rR1, fun3, imm[4:0], opCODE};
            FMT_B: enc_c = {imm[12], imm[10:5], rR2, rR1, fun3, imm[4:1], imm[11], opCODE};
            FMT_U: enc_c = {imm[31:12], wR, opCODE};
            FMT_J: enc_c = {imm[20], imm[10:1], imm[11], imm[19:12], wR, opCODE};
            default: legal_c = 1'b0;
        endcase
    end

    // alive keeps in_ready low while in reset; full blocks accepts even on a pop.
    assign in_ready  = alive && !clear && (level < LW'(DEPTH));
    assign accept_c  = in_valid && in_ready;
    assign push_c    = accept_c && legal_c;
    assign mem_we    = (level != '0);
    assign pop_c     = mem_we && mem_ready && !clear;
    assign mem_wdata = buf_q[rd_ptr];

    // Payload storage carries no reset.
    always_ff @(posedge clk) begin
        if (push_c) begin
            buf_q[wr_ptr] <= enc_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive    <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            mem_addr <= '0;
            err      <= 1'b0;
        end else if (clear) begin
            alive    <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            mem_addr <= '0;
            err      <= 1'b0;
        end else begin
            alive <= 1'b1;
            if (push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr   <= rd_ptr + AW'(1);
                mem_addr <= mem_addr + ADDR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (accept_c && !legal_c) begin
                err <= 1'b1;
            end
        end
    end

endmodule
